// File: rtl/rf_pkg.sv
// Shared register-file constants and the writeback request record
// used by the writeback scheduler and its arbiter.
package rf_pkg;
  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned NUM_REGS   = 32;
  localparam int unsigned XLEN_DEF   = 32;

  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN_DEF-1:0]   data;
  } wb_req_t;
endpackage

// File: rtl/regfile_wb_scheduler_arbiter.sv
// Two-way writeback arbiter: load unit has priority, but an ALU request
// that has lost STARVE_LIMIT consecutive cycles is forced through once.
module wb_arbiter
  import rf_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 3
) (
  input  logic    clk,
  input  logic    reset,
  input  wb_req_t alu_req,
  input  wb_req_t mem_req,
  output logic    alu_grant,
  output logic    mem_grant,
  output wb_req_t win
);

  logic [3:0] starve_cnt;
  logic       force_alu;

  assign force_alu = alu_req.valid && (starve_cnt == 4'(STARVE_LIMIT));

  // No handshake is offered while reset is held.
  always_comb begin
    alu_grant = 1'b0;
    mem_grant = 1'b0;
    if (!reset) begin
      alu_grant = alu_req.valid && (force_alu || !mem_req.valid);
      mem_grant = mem_req.valid && !alu_grant;
    end
    win       = alu_grant ? alu_req : mem_req;
    win.valid = alu_grant || mem_grant;
  end

  always_ff @(posedge clk) begin
    if (reset || !alu_req.valid || alu_grant)
      starve_cnt <= '0;
    else if (starve_cnt != 4'(STARVE_LIMIT))
      starve_cnt <= starve_cnt + 4'd1;
  end

endmodule

// File: rtl/regfile_wb_scheduler.sv
// Register-file write-port owner: arbitrates ALU/load writeback, registers
// the write, tracks outstanding destinations and stalls hazardous issue.
module regfile_wb_scheduler
  import rf_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 3,
  parameter int unsigned XLEN         = XLEN_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  issue_valid,
  input  logic [REG_ADDR_W-1:0] issue_rs1,
  input  logic [REG_ADDR_W-1:0] issue_rs2,
  input  logic [REG_ADDR_W-1:0] issue_rd,
  output logic                  issue_stall,
  input  logic                  alu_valid,
  input  logic [REG_ADDR_W-1:0] alu_rd,
  input  logic [XLEN-1:0]       alu_data,
  output logic                  alu_ready,
  input  logic                  mem_valid,
  input  logic [REG_ADDR_W-1:0] mem_rd,
  input  logic [XLEN-1:0]       mem_data,
  output logic                  mem_ready,
  output logic                  rf_we,
  output logic [REG_ADDR_W-1:0] rf_rd,
  output logic [XLEN-1:0]       rf_wdata,
  output logic [NUM_REGS-1:0]   busy_mask,
  output logic                  wb_unexpected
);

  wb_req_t               alu_req, mem_req, win;
  logic                  win_write;
  logic                  issue_accept;
  logic [NUM_REGS-1:0]   busy, busy_next;

  assign alu_req = '{valid: alu_valid, rd: alu_rd, data: XLEN_DEF'(alu_data)};
  assign mem_req = '{valid: mem_valid, rd: mem_rd, data: XLEN_DEF'(mem_data)};

  wb_arbiter #(.STARVE_LIMIT(STARVE_LIMIT)) u_arb (
    .clk       (clk),
    .reset     (reset),
    .alu_req   (alu_req),
    .mem_req   (mem_req),
    .alu_grant (alu_ready),
    .mem_grant (mem_ready),
    .win       (win)
  );

  // x0 writes complete the handshake but never reach the register file.
  assign win_write = win.valid && (win.rd != '0);

  always_comb begin
    issue_stall = issue_valid &&
                  (((issue_rs1 != '0) && busy[issue_rs1]) ||
                   ((issue_rs2 != '0) && busy[issue_rs2]) ||
                   ((issue_rd  != '0) && busy[issue_rd]));
  end

  assign issue_accept = issue_valid && !issue_stall && (issue_rd != '0);

  // Clear tracks the register-file commit edge; a same-edge set overrides it.
  always_comb begin
    busy_next = busy;
    if (rf_we)
      busy_next[rf_rd] = 1'b0;
    if (issue_accept)
      busy_next[issue_rd] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rf_we         <= 1'b0;
      rf_rd         <= '0;
      rf_wdata      <= '0;
      busy          <= '0;
      wb_unexpected <= 1'b0;
    end else begin
      rf_we <= win_write;
      if (win_write) begin
        rf_rd    <= win.rd;
        rf_wdata <= XLEN'(win.data);
      end
      busy          <= busy_next;
      wb_unexpected <= wb_unexpected || (win_write && !busy[win.rd]);
    end
  end

  assign busy_mask = busy;

endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// Directed bench for regfile_wb_scheduler: a cycle-level behavioural model
// is compared every cycle, plus hand-computed literal checkpoints.
module tb_regfile_wb_scheduler;
  localparam int unsigned LIMIT = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic        issue_valid;
  logic [4:0]  issue_rs1, issue_rs2, issue_rd;
  logic        issue_stall;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        alu_ready;
  logic        mem_valid;
  logic [4:0]  mem_rd;
  logic [31:0] mem_data;
  logic        mem_ready;
  logic        rf_we;
  logic [4:0]  rf_rd;
  logic [31:0] rf_wdata;
  logic [31:0] busy_mask;
  logic        wb_unexpected;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  always #5 clk = ~clk;

  regfile_wb_scheduler #(.STARVE_LIMIT(LIMIT), .XLEN(32)) dut (
    .clk(clk), .reset(reset),
    .issue_valid(issue_valid), .issue_rs1(issue_rs1), .issue_rs2(issue_rs2),
    .issue_rd(issue_rd), .issue_stall(issue_stall),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
    .mem_valid(mem_valid), .mem_rd(mem_rd), .mem_data(mem_data), .mem_ready(mem_ready),
    .rf_we(rf_we), .rf_rd(rf_rd), .rf_wdata(rf_wdata),
    .busy_mask(busy_mask), .wb_unexpected(wb_unexpected)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit          m_busy [32];
  bit          m_we;
  int unsigned m_rd;
  logic [31:0] m_wd;
  bit          m_unexp;
  int unsigned m_losses;

  function automatic bit reg_busy(input logic [4:0] r);
    return (r != 0) && m_busy[r];
  endfunction

  function automatic bit exp_stall();
    return issue_valid && (reg_busy(issue_rs1) || reg_busy(issue_rs2) || reg_busy(issue_rd));
  endfunction

  function automatic bit exp_alu_win();
    if (reset || !alu_valid) return 1'b0;
    return !mem_valid || (m_losses >= LIMIT);
  endfunction

  function automatic bit exp_mem_win();
    return !reset && mem_valid && !exp_alu_win();
  endfunction

  function automatic logic [31:0] exp_mask();
    logic [31:0] v = '0;
    for (int i = 0; i < 32; i++) v[i] = m_busy[i];
    return v;
  endfunction

  initial begin
    for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
    m_we = 0; m_rd = 0; m_wd = '0; m_unexp = 0; m_losses = 0;
  end

  always @(posedge clk) begin
    bit          aw, mw, st, we_n;
    int unsigned wrd;
    logic [31:0] wdat;
    aw = exp_alu_win();
    mw = exp_mem_win();
    st = exp_stall();
    if (reset) begin
      for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
      m_we = 0; m_rd = 0; m_wd = '0; m_unexp = 0; m_losses = 0;
    end else begin
      wrd  = aw ? alu_rd : mem_rd;
      wdat = aw ? alu_data : mem_data;
      we_n = (aw || mw) && (wrd != 0);
      if (we_n && !m_busy[wrd]) m_unexp = 1;
      if (m_we) m_busy[m_rd] = 0;
      if (issue_valid && !st && issue_rd != 0) m_busy[issue_rd] = 1;
      m_we = we_n;
      if (we_n) begin m_rd = wrd; m_wd = wdat; end
      m_losses = (alu_valid && !aw) ? ((m_losses < LIMIT) ? m_losses + 1 : LIMIT) : 0;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("stall", {31'b0, issue_stall}, {31'b0, exp_stall()});
      check("alu_ready", {31'b0, alu_ready}, {31'b0, exp_alu_win()});
      check("mem_ready", {31'b0, mem_ready}, {31'b0, exp_mem_win()});
      check("rf_we", {31'b0, rf_we}, {31'b0, m_we});
      if (m_we) begin
        check("rf_rd", {27'b0, rf_rd}, m_rd);
        check("rf_wdata", rf_wdata, m_wd);
      end
      check("busy_mask", busy_mask, exp_mask());
      check("wb_unexpected", {31'b0, wb_unexpected}, {31'b0, m_unexp});
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic issue(input logic v, input logic [4:0] s1, input logic [4:0] s2, input logic [4:0] d);
    issue_valid = v; issue_rs1 = s1; issue_rs2 = s2; issue_rd = d;
  endtask

  task automatic alu(input logic v, input logic [4:0] d, input logic [31:0] x);
    alu_valid = v; alu_rd = d; alu_data = x;
  endtask

  task automatic mem(input logic v, input logic [4:0] d, input logic [31:0] x);
    mem_valid = v; mem_rd = d; mem_data = x;
  endtask

  logic [7:0] starve_pat;

  initial begin
    reset = 1'b1;
    issue(0, 0, 0, 0); alu(0, 0, 0); mem(0, 0, 0);
    tick();
    chk_en = 1'b1;
    tick();
    reset = 1'b0;
    settle();
    check("lit_reset_we", {31'b0, rf_we}, 32'd0);
    check("lit_reset_rd", {27'b0, rf_rd}, 32'd0);
    check("lit_reset_wdata", rf_wdata, 32'd0);
    check("lit_reset_busy", busy_mask, 32'd0);

    // issue into idle scoreboard
    tick();
    issue(1, 5, 6, 7);
    settle();
    check("lit_idle_stall", {31'b0, issue_stall}, 32'd0);
    tick();
    issue(0, 0, 0, 0);
    settle();
    check("lit_busy7", busy_mask, 32'h80);

    // RAW hazard resolved by ALU writeback
    tick();
    issue(1, 7, 0, 0);
    alu(1, 7, 32'h1234);
    settle();
    check("lit_raw_stall", {31'b0, issue_stall}, 32'd1);
    check("lit_raw_ready", {31'b0, alu_ready}, 32'd1);
    tick();
    alu(0, 0, 0);
    settle();
    check("lit_raw_we", {31'b0, rf_we}, 32'd1);
    check("lit_raw_rd", {27'b0, rf_rd}, 32'd7);
    check("lit_raw_data", rf_wdata, 32'h1234);
    check("lit_raw_still_stall", {31'b0, issue_stall}, 32'd1);
    tick();
    settle();
    check("lit_raw_clear", busy_mask, 32'd0);
    check("lit_raw_go", {31'b0, issue_stall}, 32'd0);
    tick();

    // collision: mem first, ALU next cycle
    issue(1, 0, 0, 3); tick();
    issue(1, 0, 0, 4); tick();
    issue(0, 0, 0, 0);
    alu(1, 3, 32'hAAAA_0003);
    mem(1, 4, 32'hBBBB_0004);
    settle();
    check("lit_col_mem", {31'b0, mem_ready}, 32'd1);
    check("lit_col_alu0", {31'b0, alu_ready}, 32'd0);
    tick();
    mem(0, 0, 0);
    settle();
    check("lit_col_alu1", {31'b0, alu_ready}, 32'd1);
    check("lit_col_rd4", {27'b0, rf_rd}, 32'd4);
    tick();
    alu(0, 0, 0);
    settle();
    check("lit_col_rd3", {27'b0, rf_rd}, 32'd3);
    check("lit_col_data3", rf_wdata, 32'hAAAA_0003);
    tick();
    settle();
    check("lit_col_we_off", {31'b0, rf_we}, 32'd0);
    tick();

    // starvation: ALU loses three, wins the fourth, then counter restarts
    starve_pat = 8'b1000_1000;
    alu(1, 0, 32'h1);
    mem(1, 0, 32'h2);
    for (int i = 0; i < 8; i++) begin
      settle();
      check("lit_starve_alu", {31'b0, alu_ready}, {31'b0, starve_pat[i]});
      tick();
    end
    alu(0, 0, 0); mem(0, 0, 0);

    // x0 write then unexpected write to x9
    alu(1, 0, 32'hFFFF_FFFF);
    settle();
    check("lit_x0_ready", {31'b0, alu_ready}, 32'd1);
    tick();
    alu(1, 9, 32'h99);
    settle();
    check("lit_x0_we", {31'b0, rf_we}, 32'd0);
    check("lit_x0_unexp", {31'b0, wb_unexpected}, 32'd0);
    tick();
    alu(0, 0, 0);
    settle();
    check("lit_x9_unexp", {31'b0, wb_unexpected}, 32'd1);
    tick();

    // set wins over clear: issue rd=5 accepted on the edge x5 commits
    alu(1, 5, 32'h55);
    tick();
    alu(0, 0, 0);
    issue(1, 0, 0, 5);
    settle();
    check("lit_sc_stall", {31'b0, issue_stall}, 32'd0);
    tick();
    issue(0, 0, 0, 0);
    settle();
    check("lit_sc_busy5", busy_mask, 32'h20);

    // reset with a write pending
    tick();
    alu(1, 5, 32'h77);
    tick();
    reset = 1'b1;
    settle();
    check("lit_rst_ready", {31'b0, alu_ready}, 32'd0);
    tick();
    alu(0, 0, 0);
    settle();
    check("lit_rst_we", {31'b0, rf_we}, 32'd0);
    check("lit_rst_busy", busy_mask, 32'd0);
    reset = 1'b0;
    tick();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
